// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with glitch-filtered clock, odd-parity frame checking and a FWFT byte FIFO
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2c,
  input  logic                          ps2d,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fclk, r_fclk_d;
  state_t                r_state;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_par;
  logic [TW-1:0]         r_tmo;
  logic                  r_parity_err, r_frame_err, r_overflow;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_count;

  logic w_fall, w_par_ok, w_push, w_pop, w_full, w_wr, w_drop;

  // Synchronizers and filter idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_s1   <= 1'b1;
      r_c_s2   <= 1'b1;
      r_d_s1   <= 1'b1;
      r_d_s2   <= 1'b1;
      r_filt   <= '1;
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
    end else begin
      r_c_s1   <= ps2c;
      r_c_s2   <= r_c_s1;
      r_d_s1   <= ps2d;
      r_d_s2   <= r_d_s1;
      r_filt   <= {r_filt[FILTER_LEN-2:0], r_c_s2};
      if (r_filt == '0)
        r_fclk <= 1'b0;
      else if (&r_filt)
        r_fclk <= 1'b1;
      r_fclk_d <= r_fclk;
    end
  end

  assign w_fall   = r_fclk_d & ~r_fclk;
  assign w_par_ok = ^{r_shift, r_par};
  assign w_push   = w_fall && (r_state == STOP) && r_d_s2 && w_par_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall && !r_d_s2) begin
            r_state  <= DATA;
            r_bitcnt <= 3'd0;
          end
        end
        DATA: begin
          if (w_fall) begin
            r_shift  <= {r_d_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= PARITY;
          end
        end
        PARITY: begin
          if (w_fall) begin
            r_par   <= r_d_s2;
            r_state <= STOP;
          end
        end
        default: begin
          if (w_fall) begin
            r_state <= IDLE;
            if (!r_d_s2)
              r_frame_err <= 1'b1;
            else if (!w_par_ok)
              r_parity_err <= 1'b1;
          end
        end
      endcase
      // Fall handling and timeout are mutually exclusive within a cycle.
      if (r_state == IDLE) begin
        r_tmo <= '0;
      end else if (w_fall) begin
        r_tmo <= '0;
      end else if (r_tmo == TMO_MAX) begin
        r_tmo       <= '0;
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  assign w_full = (r_count == DEPTH);
  assign w_pop  = (r_count != '0) && dout_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst_n && w_wr)
      r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop)
        r_count <= r_count - (AW+1)'(1);
      if (w_drop)
        r_overflow <= 1'b1;
      else if (ovf_clr)
        r_overflow <= 1'b0;
    end
  end

  assign dout_valid = (r_count != '0);
  assign dout       = dout_valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count = r_count;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FILTER_LEN, default 8: ps2c glitch-filter length in clk cycles, legal range 2..32.
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte buffer depth, power of two, legal range 2..64.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles allowed between ps2c falling edges inside a frame.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port ps2c, input, 1 bit: raw PS/2 clock, asynchronous.
REQ-007 Port ps2d, input, 1 bit: raw PS/2 data, asynchronous.
REQ-008 Port dout, output, 8 bits: head-of-FIFO byte.
REQ-009 Port dout_valid, output, 1 bit: FIFO not empty.
REQ-010 Port dout_ready, input, 1 bit: consumer accepts the head byte.
REQ-011 Port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-012 Port parity_err, output, 1 bit: one-cycle pulse on a parity failure.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit or a timeout.
REQ-014 Port overflow, output, 1 bit: sticky flag, set when a frame is dropped.
REQ-015 Port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-016 ps2c and ps2d SHALL each pass through a 2-flop synchronizer.
REQ-017 Synchronized ps2c SHALL shift into a FILTER_LEN-bit register; filtered clock goes to 0 when all bits are 0, to 1 when all bits are 1, and holds otherwise.
REQ-018 A fall event SHALL be a one-cycle strobe, asserted the cycle after the filtered clock transitions 1->0.
REQ-019 Synchronized ps2d SHALL be sampled only on fall events.
REQ-020 The FSM SHALL have four states: IDLE, DATA, PARITY, STOP.
REQ-021 IDLE: a fall event with ps2d=0 goes to DATA with the bit counter at 0; a fall event with ps2d=1 is ignored without error.
REQ-022 DATA: each fall event shifts ps2d in LSB-first; after the 8th bit the FSM goes to PARITY.
REQ-023 PARITY: the fall event samples the parity bit; the FSM goes to STOP.
REQ-024 Parity is odd: the XOR of the 8 data bits and the parity bit must equal 1.
REQ-025 STOP, on the fall event, the FSM returns to IDLE and:
- if ps2d=0, frame_err pulses and the byte is discarded (whatever the parity result);
- else if parity failed, parity_err pulses and the byte is discarded;
- else the byte is pushed.
REQ-026 Both error pulses SHALL assert in the cycle after the STOP fall event.
REQ-027 Timeout counter: clears on every fall event and counts clk cycles while not in IDLE.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES, frame_err SHALL pulse, the partial byte is discarded and the FSM goes to IDLE.
REQ-029 A push SHALL write the FIFO on the clock edge of the STOP fall event; dout_valid rises the following cycle.
REQ-030 The FIFO SHALL be first-word-fall-through: dout always shows the oldest byte while dout_valid=1.
REQ-031 A pop SHALL occur when dout_valid and dout_ready are both 1.
REQ-032 dout_ready SHALL have no effect when the FIFO is empty.
REQ-033 Push when full without a same-cycle pop: the byte is dropped, overflow is set, and FIFO contents are unchanged.
REQ-034 Push and pop in the same cycle when full: both succeed and fifo_count stays at FIFO_DEPTH.
REQ-035 Push and pop in the same cycle when not full: both succeed and fifo_count is unchanged.
REQ-036 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 ovf_clr=1 SHALL clear overflow; if a set condition occurs in the same cycle, the set wins.

Reset
REQ-038 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE, and the bit counter, timeout counter, FIFO pointers and fifo_count SHALL go to 0.
REQ-039 While rst_n=0 at a clk edge, the filter register and filtered clock SHALL go to all 1s, and both synchronizers SHALL be set to 1.
REQ-040 Reset output values SHALL be: dout_valid=0, dout=8'h00, parity_err=0, frame_err=0, overflow=0.
REQ-041 Reset asserted mid-frame SHALL discard the partial frame with no error pulse.
REQ-042 FIFO contents SHALL be lost on reset.

Verification
REQ-043 Frame start 0, data 0x1C, parity 0, stop 1 (ps2c period 100 clk) -> dout=0x1C, dout_valid=1, fifo_count=1, no error pulses.
REQ-044 Same frame with parity 1 -> exactly one parity_err pulse, dout_valid stays 0.
REQ-045 Frame 0x1C with stop bit 0 -> one frame_err pulse, no push.
REQ-046 Start bit plus 3 data bits, then ps2c idle for TIMEOUT_CYCLES+10 -> one frame_err pulse, FSM in IDLE; a following frame 0xF0 with parity 1 -> dout=0xF0.
REQ-047 FIFO_DEPTH=4, five valid frames 0x01..0x05 with dout_ready=0 -> fifo_count=4, overflow=1; draining yields 0x01..0x04 in order, then dout_valid=0; ovf_clr then gives overflow=0.
REQ-048 ps2c low glitch of FILTER_LEN-1 cycles in IDLE -> no fall event and no state change.
REQ-049 rst_n low for 1 cycle mid-frame -> no error pulse; a following clean frame 0x5A with parity 1 -> dout=0x5A.
